// File: rtl/branch_predictor.sv
// branch_predictor
//   IF-stage next-PC predictor. A direct-mapped, tagged table holds one
//   target and one 2-bit saturating direction counter per entry. The
//   lookup is purely combinational from PC_IF. Training comes from branch
//   resolution in EX. A registered one-cycle Mispredict pulse with
//   Redirect_PC tells fetch where to restart.
//
// Ports
//   CLK, RSTn        clock (rising edge), asynchronous active-low reset
//   PC_IF            current fetch PC
//   PredTaken        lookup hit with counter in a taken state
//   PredTarget       predicted next fetch PC (stored target or PC_IF+4)
//   Upd_valid        EX resolved a branch/jump this cycle
//   Upd_PC           PC of the resolved instruction
//   Upd_taken        actual direction
//   Upd_target       actual taken target
//   Upd_predTaken    PredTaken carried down from IF
//   Upd_predTarget   PredTarget carried down from IF
//   Mispredict       registered redirect pulse
//   Redirect_PC      correct next PC, valid while Mispredict=1
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] PC_IF,
    output logic        PredTaken,
    output logic [31:0] PredTarget,
    input  logic        Upd_valid,
    input  logic [31:0] Upd_PC,
    input  logic        Upd_taken,
    input  logic [31:0] Upd_target,
    input  logic        Upd_predTaken,
    input  logic [31:0] Upd_predTarget,
    output logic        Mispredict,
    output logic [31:0] Redirect_PC
);

    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WN = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    // Table state
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    // Registered redirect outputs
    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    // Lookup and update decode
    logic [IDX_W-1:0] lk_idx_s, up_idx_s;
    logic [TAG_W-1:0] lk_tag_s, up_tag_s;
    logic             lk_hit_s, up_hit_s, wrong_s;

    // Byte-offset bits of both PCs play no part in indexing or tagging
    logic unused_bits;
    assign unused_bits = ^{PC_IF[1:0], Upd_PC[1:0]};

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SN) ? CTR_SN : c - 2'd1;
    endfunction

    // Combinational lookup; during reset valid_q is already clear so it misses
    always_comb begin
        lk_idx_s   = PC_IF[IDX_W+1:2];
        lk_tag_s   = PC_IF[31:IDX_W+2];
        lk_hit_s   = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        PredTaken  = lk_hit_s && ctr_q[lk_idx_s][1];
        if (PredTaken) begin
            PredTarget = target_q[lk_idx_s];
        end else begin
            PredTarget = PC_IF + 32'd4;
        end
    end

    // Next-state for the table and the redirect registers
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        up_idx_s = Upd_PC[IDX_W+1:2];
        up_tag_s = Upd_PC[31:IDX_W+2];
        up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
        wrong_s  = (Upd_taken != Upd_predTaken) ||
                   (Upd_taken && (Upd_target != Upd_predTarget));
        mispredict_d  = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (Upd_valid) begin
            mispredict_d  = wrong_s;
            redirect_pc_d = Upd_taken ? Upd_target : (Upd_PC + 32'd4);
            case ({up_hit_s, Upd_taken})
                2'b11: begin
                    ctr_d[up_idx_s]    = ctr_inc(ctr_q[up_idx_s]);
                    target_d[up_idx_s] = Upd_target;
                end
                2'b10: begin
                    ctr_d[up_idx_s] = ctr_dec(ctr_q[up_idx_s]);
                end
                2'b01: begin
                    // Allocate over whatever occupies the slot
                    valid_d[up_idx_s]  = 1'b1;
                    tag_d[up_idx_s]    = up_tag_s;
                    target_d[up_idx_s] = Upd_target;
                    ctr_d[up_idx_s]    = CTR_WT;
                end
                default: begin
                    // Miss, not taken: nothing to learn
                end
            endcase
        end else begin
            mispredict_d = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid_q       <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_WN;
            end
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign Mispredict  = mispredict_q;
    assign Redirect_PC = redirect_pc_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

IF-stage next-PC predictor: a direct-mapped, tagged table of branch/jump targets with a 2-bit saturating direction counter per entry. Combinationally predicts the next fetch PC from the current IF PC. Trains from branch resolution in EX. Emits a registered one-cycle mispredict/redirect pulse to the fetch unit when a resolved branch contradicts the prediction carried down the pipeline.

## Interface
Parameters:
- ENTRIES, 16, number of table entries (power of two)
- IDX_W, 4, log2(ENTRIES); index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2]

Ports:
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- PC_IF  in  32  current fetch PC (IF stage)
- PredTaken  out  1  prediction for PC_IF: taken (combinational)
- PredTarget  out  32  predicted next fetch PC (combinational)
- Upd_valid  in  1  EX stage resolved a branch/jump this cycle
- Upd_PC  in  32  PC of the resolved instruction
- Upd_taken  in  1  actual direction
- Upd_target  in  32  actual taken target
- Upd_predTaken  in  1  PredTaken carried with the instruction from IF
- Upd_predTarget  in  32  PredTarget carried with the instruction from IF
- Mispredict  out  1  registered one-cycle redirect pulse
- Redirect_PC  out  32  correct next PC, valid while Mispredict=1

## Operation
- Per entry: valid, tag (32-IDX_W-2 bits), target (32), ctr (2). Counter states: SN=00, WN=01, WT=10, ST=11.
- Lookup: hit = valid[idx] & tag[idx]==PC_IF tag. PredTaken = hit & ctr[idx][1]. PredTarget = PredTaken ? target[idx] : PC_IF+4 (mod 2^32).
- Update when Upd_valid=1, entry at Upd_PC index:
  - Hit, taken: ctr saturating +1 (ST stays ST); target <= Upd_target.
  - Hit, not taken: ctr saturating -1 (SN stays SN); target unchanged.
  - Miss, taken: allocate, replacing any occupant: valid=1, tag, target=Upd_target, ctr=WT.
  - Miss, not taken: no change.
- Mispredict check, when Upd_valid=1: wrong = (Upd_taken != Upd_predTaken) | (Upd_taken & Upd_target != Upd_predTarget).
- Redirect_PC = Upd_taken ? Upd_target : Upd_PC+4.
- Upd_valid=0: table and registered outputs get no update; Mispredict=0 next cycle.

## Timing
- Lookup: zero latency, purely combinational from PC_IF and table state.
- Update: the table is written at the rising edge of the Upd_valid cycle.
- Same-cycle lookup and update of the same index: the lookup sees pre-update contents. There is no bypass.
- Mispredict/Redirect_PC are registered. They are asserted in the cycle after Upd_valid and last exactly one cycle unless the next update also mispredicts.
- Back-to-back updates are accepted every cycle. There is no stall or handshake.
- Reset (RSTn=0, asynchronous, effective immediately, including mid-operation):
  - All valid=0, all ctr=WN, all target=0, all tag=0.
  - Mispredict=0, Redirect_PC=0.
  - PredTaken=0 and PredTarget=PC_IF+4 while in reset.
- First update after RSTn rises takes effect at the first rising edge with RSTn=1.

## Test plan
- Cold lookup: after reset, PC_IF=0x100 -> PredTaken=0, PredTarget=0x104. PC_IF=0xFFFFFFFC -> PredTarget=0x00000000 (wrap).
- Allocate + mispredict: update PC=0x100, taken, target 0x200, predTaken=0 -> next cycle Mispredict=1, Redirect_PC=0x200, one-cycle pulse. Then PC_IF=0x100 -> PredTaken=1, PredTarget=0x200.
- Counter walk on 0x100 (starting at WT): two not-taken updates -> WN then SN, PredTaken=0, Redirect_PC=0x104 on the first. One taken -> WN, still 0. Second taken -> WT, 1. Three more taken -> saturates at ST. One not-taken -> WT, still 1.
- Target change: entry 0x100->0x200 at ST. Update taken, target 0x300, predTaken=1, predTarget=0x200 -> Mispredict=1, Redirect_PC=0x300. Next lookup PredTarget=0x300.
- Aliasing (ENTRIES=16): 0x140 shares index 0 with 0x100. Lookup 0x140 misses. Taken update of 0x140 -> 0x500 replaces the entry, so 0x100 now misses (PredTarget=0x104). A same-cycle lookup of 0x140 during that update still returns the old miss.
- Async reset mid-pulse: assert RSTn=0 while Mispredict=1, between clock edges -> Mispredict=0 immediately. After release, all earlier entries miss.
